// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// funct3 encodings follow the RISC-V load/store size/sign field.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Byte-enable mask for an access of 2**size bytes at a byte offset within a 64-bit word.
   function automatic logic [7:0] be_for(input logic [1:0] size, input logic [2:0] offset);
      logic [7:0] be;
      case (size)
         2'd0:    be = 8'h01 << offset;
         2'd1:    be = 8'h03 << offset;
         2'd2:    be = 8'h0F << offset;
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane handling: store replication and byte enables,
// load lane extraction with sign/zero extension.
module lsu_data_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [2:0]                        st_funct3,
   input  logic [$clog2(DATA_WIDTH/8)-1:0]   st_offset,
   input  logic [DATA_WIDTH-1:0]             st_data,
   output logic [DATA_WIDTH/8-1:0]           st_be,
   output logic [DATA_WIDTH-1:0]             st_wdata,
   input  logic [2:0]                        ld_funct3,
   input  logic [$clog2(DATA_WIDTH/8)-1:0]   ld_offset,
   input  logic [DATA_WIDTH-1:0]             ld_word,
   output logic [DATA_WIDTH-1:0]             ld_data
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic [7:0]            be8;
   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      be8   = be_for(st_funct3[1:0], 3'(st_offset));
      st_be = be8[BE_W-1:0];
   end

   always_comb begin
      case (st_funct3[1:0])
         2'd0:    st_wdata = {BE_W{st_data[7:0]}};
         2'd1:    st_wdata = {(BE_W/2){st_data[15:0]}};
         2'd2:    st_wdata = {(BE_W/4){st_data[31:0]}};
         default: st_wdata = st_data;
      endcase
   end

   // The addressed lane is brought down to bit 0 before extension.
   always_comb begin
      shifted = ld_word >> {ld_offset, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = DATA_WIDTH'($signed(shifted[7:0]));
         F3_H:    ld_data = DATA_WIDTH'($signed(shifted[15:0]));
         F3_W:    ld_data = DATA_WIDTH'($signed(shifted[31:0]));
         F3_BU:   ld_data = DATA_WIDTH'(shifted[7:0]);
         F3_HU:   ld_data = DATA_WIDTH'(shifted[15:0]);
         F3_WU:   ld_data = DATA_WIDTH'(shifted[31:0]);
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/mm_stage_lsu.sv
// Memory-stage load/store unit: issues one valid/ready data-memory access per
// memory instruction and stalls upstream until it completes.
module mm_stage_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      reg_write_in,
   input  logic                      mem_read_in,
   input  logic                      mem_write_in,
   input  logic [2:0]                funct3_in,
   input  logic [DATA_WIDTH-1:0]     alu_result_in,
   input  logic [DATA_WIDTH-1:0]     write_data_in,
   input  logic [4:0]                rd_in,
   output logic                      dmem_req_valid,
   input  logic                      dmem_req_ready,
   output logic                      dmem_we,
   output logic [ADDR_WIDTH-1:0]     dmem_addr,
   output logic [DATA_WIDTH/8-1:0]   dmem_be,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   input  logic                      dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     dmem_rsp_data,
   output logic [DATA_WIDTH-1:0]     mem_data_out,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [4:0]                rd_out,
   output logic                      reg_write_out,
   output logic                      stall_out,
   output logic                      misalign_out
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BE_W);

   lsu_state_t            state;
   logic                  mem_op;
   logic                  misaligned;
   logic                  issue;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [OFF_W-1:0]      offset;
   logic [OFF_W-1:0]      offset_q;
   logic [2:0]            funct3_q;
   logic [BE_W-1:0]       st_be;
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [DATA_WIDTH-1:0] ld_data;

   // D never fits a 32-bit word, and WU has no meaning there either.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] low,
                                          input logic is_load);
      logic m;
      case (f3)
         F3_B, F3_BU: m = 1'b0;
         F3_H, F3_HU: m = low[0];
         F3_W:        m = |low[1:0];
         F3_WU:       m = |low[1:0] || (DATA_WIDTH == 32 && is_load);
         F3_D:        m = |low || (DATA_WIDTH == 32);
         default:     m = 1'b1;
      endcase
      return m;
   endfunction

   generate
      if (ADDR_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
         assign eff_addr = alu_result_in[ADDR_WIDTH-1:0];
      end else begin : g_addr_ext
         assign eff_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, alu_result_in};
      end
   endgenerate

   assign offset     = alu_result_in[OFF_W-1:0];
   assign mem_op     = mem_read_in | mem_write_in;
   assign misaligned = is_misaligned(funct3_in, alu_result_in[2:0], !mem_write_in);
   assign issue      = (state == S_IDLE) && mem_op && !misaligned;

   lsu_data_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .st_funct3 (funct3_in),
      .st_offset (offset),
      .st_data   (write_data_in),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (funct3_q),
      .ld_offset (offset_q),
      .ld_word   (dmem_rsp_data),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         dmem_req_valid <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_be        <= '0;
         dmem_wdata     <= '0;
         funct3_q       <= 3'b000;
         offset_q       <= '0;
         mem_data_out   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue) begin
                  dmem_req_valid <= 1'b1;
                  dmem_we        <= mem_write_in;
                  dmem_addr      <= {eff_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  dmem_be        <= st_be;
                  dmem_wdata     <= st_wdata;
                  funct3_q       <= funct3_in;
                  offset_q       <= offset;
                  state          <= S_REQ;
               end
            end
            S_REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  state          <= dmem_we ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_rsp_valid) begin
                  mem_data_out <= ld_data;
                  state        <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign stall_out      = issue || (state == S_REQ) || (state == S_WAIT);
   assign misalign_out   = (state == S_IDLE) && mem_op && misaligned;
   assign reg_write_out  = reg_write_in &&
                           (((state == S_IDLE) && !mem_op) || (state == S_DONE));
   assign alu_result_out = alu_result_in;
   assign rd_out         = rd_in;

endmodule

// File: tb/tb_mm_stage_lsu.sv
// Directed and randomized checks of mm_stage_lsu against a behavioural
// model of the load/store rules (64-bit configuration).
module tb_mm_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reg_write_in, mem_read_in, mem_write_in;
   logic [2:0]  funct3_in;
   logic [63:0] alu_result_in, write_data_in;
   logic [4:0]  rd_in;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [63:0] dmem_addr;
   logic [7:0]  dmem_be;
   logic [63:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [63:0] dmem_rsp_data;
   logic [63:0] mem_data_out, alu_result_out;
   logic [4:0]  rd_out;
   logic        reg_write_out, stall_out, misalign_out;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] last_load = 64'd0;

   mm_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .funct3_in(funct3_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
      .rd_in(rd_in),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
      .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
      .reg_write_out(reg_write_out), .stall_out(stall_out), .misalign_out(misalign_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- reference model: plain arithmetic on access size and offset ----
   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2, 3'd6: return 4;
         default:    return 8;
      endcase
   endfunction

   function automatic logic [63:0] lane_mask(input int n);
      return (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
   endfunction

   function automatic bit m_mis(input logic [2:0] f3, input logic [63:0] addr);
      if (f3 == 3'd7) return 1'b1;
      return (addr % 64'(nbytes(f3))) != 64'd0;
   endfunction

   function automatic logic [7:0] m_be(input logic [2:0] f3, input logic [63:0] addr);
      int n = nbytes(f3);
      int v = ((1 << n) - 1) << int'(addr % 64'd8);
      return 8'(v);
   endfunction

   function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [63:0] sd);
      int n = nbytes(f3);
      logic [63:0] low = sd & lane_mask(n);
      logic [63:0] r = 64'd0;
      for (int k = 0; k < 8 / n; k++) r = r | (low << (8 * n * k));
      return r;
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                          input logic [63:0] word);
      int n = nbytes(f3);
      logic [63:0] m = lane_mask(n);
      logic [63:0] v = (word >> (8 * int'(addr % 64'd8))) & m;
      bit sgn = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      if (sgn && n < 8 && v[8*n-1]) v = v | ~m;
      return v;
   endfunction

   task automatic idle_inputs();
      reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
      funct3_in = 3'd0; alu_result_in = 64'd0; write_data_in = 64'd0; rd_in = 5'd0;
   endtask

   task automatic alu_op(input logic rw, input logic [63:0] res, input logic [4:0] rd);
      reg_write_in = rw; mem_read_in = 1'b0; mem_write_in = 1'b0;
      alu_result_in = res; rd_in = rd; funct3_in = 3'($urandom_range(0, 6));
      @(negedge clk);
      check("alu_result_out", alu_result_out, res);
      check("alu_rd_out", 64'(rd_out), 64'(rd));
      check("alu_reg_write", 64'(reg_write_out), 64'(rw));
      check("alu_stall", 64'(stall_out), 64'd0);
      check("alu_req_valid", 64'(dmem_req_valid), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   // Entered and left #1 after a rising edge with the unit idle.
   task automatic mem_txn(input logic rdop, input logic wrop, input logic rw,
                          input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [63:0] rdata,
                          input int rdy_dly, input int rsp_dly);
      bit          store = wrop;
      bit          mis = m_mis(f3, addr);
      logic [7:0]  ebe = m_be(f3, addr);
      logic [63:0] ewd = m_wdata(f3, sdata);
      logic [63:0] eld = m_load(f3, addr, rdata);
      logic [63:0] eaddr = addr & ~64'd7;
      logic [4:0]  rd = 5'($urandom);
      int          stalls, w;
      bit          done;
      reg_write_in = rw; mem_read_in = rdop; mem_write_in = wrop;
      funct3_in = f3; alu_result_in = addr; write_data_in = sdata; rd_in = rd;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      @(negedge clk);
      check("mem_alu_pass", alu_result_out, addr);
      check("mem_rd_pass", 64'(rd_out), 64'(rd));
      check("issue_misalign", 64'(misalign_out), 64'(mis));
      check("issue_reg_write", 64'(reg_write_out), 64'd0);
      check("issue_req_valid", 64'(dmem_req_valid), 64'd0);
      check("issue_stall", 64'(stall_out), 64'(!mis));
      if (mis) begin
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         check("mis_no_req", 64'(dmem_req_valid), 64'd0);
         check("mis_pulse_end", 64'(misalign_out), 64'd0);
         check("mis_mem_data_hold", mem_data_out, last_load);
         @(posedge clk); #1;
         return;
      end
      stalls = 1;
      w = 0; done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(posedge clk); #1;
         dmem_req_ready = (w >= rdy_dly);
         dmem_rsp_valid = 1'($urandom);
         dmem_rsp_data = {$urandom, $urandom};
         @(negedge clk);
         check("req_valid", 64'(dmem_req_valid), 64'd1);
         check("req_addr", dmem_addr, eaddr);
         check("req_be", 64'(dmem_be), 64'(ebe));
         check("req_we", 64'(dmem_we), 64'(store));
         if (store) check("req_wdata", dmem_wdata, ewd);
         check("req_stall", 64'(stall_out), 64'd1);
         stalls++;
         if (dmem_req_ready) done = 1;
         w++;
      end
      if (!done) check("req_handshake_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (!store) begin
         w = 0; done = 0;
         for (int c = 0; c < 64 && !done; c++) begin
            dmem_rsp_valid = (w >= rsp_dly);
            dmem_rsp_data = dmem_rsp_valid ? rdata : {$urandom, $urandom};
            @(negedge clk);
            check("wait_stall", 64'(stall_out), 64'd1);
            check("wait_req_valid", 64'(dmem_req_valid), 64'd0);
            stalls++;
            if (dmem_rsp_valid) done = 1;
            w++;
            @(posedge clk); #1;
         end
         if (!done) check("rsp_timeout", 64'd0, 64'd1);
         dmem_rsp_valid = 1'b0;
         dmem_rsp_data = {$urandom, $urandom};
         last_load = eld;
      end
      @(negedge clk);
      check("done_stall", 64'(stall_out), 64'd0);
      check("done_reg_write", 64'(reg_write_out), 64'(rw));
      check("done_req_valid", 64'(dmem_req_valid), 64'd0);
      check("done_mem_data", mem_data_out, last_load);
      check("stall_cycles", 64'(stalls),
            64'(store ? (2 + rdy_dly) : (3 + rdy_dly + rsp_dly)));
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("post_no_reissue", 64'(dmem_req_valid | stall_out), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [2:0]  f3;
      logic [63:0] a;
      int          kind;
      rst_n = 1'b0;
      idle_inputs();
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = 64'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      check("rst_stall", 64'(stall_out), 64'd0);
      check("rst_misalign", 64'(misalign_out), 64'd0);
      check("rst_reg_write", 64'(reg_write_out), 64'd0);
      check("rst_mem_data", mem_data_out, 64'd0);
      check("rst_be_we", {55'd0, dmem_we, dmem_be}, 64'd0);
      check("rst_addr", dmem_addr, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset while a request is outstanding with ready low
      reg_write_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'd5; alu_result_in = 64'h5006;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_req_valid_before", 64'(dmem_req_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check("rstmid_req_valid_after", 64'(dmem_req_valid), 64'd0);
      check("rstmid_stall_after", 64'(stall_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'hDEAD_BEEF_CAFE_F00D;
      repeat (3) @(posedge clk);
      #1;
      check("rstmid_late_rsp_ignored", mem_data_out, 64'd0);
      check("rstmid_idle_no_req", 64'(dmem_req_valid), 64'd0);
      dmem_rsp_valid = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      mem_txn(1, 0, 1, 3'd0, 64'h1003, 64'd0, 64'h8877665544332211, 0, 0);
      check("lb_value", mem_data_out, 64'h44);
      mem_txn(1, 0, 1, 3'd5, 64'h2006, 64'd0, 64'hBEEF_0000_0000_0000, 4, 0);
      check("lhu_value", mem_data_out, 64'hBEEF);
      mem_txn(0, 1, 0, 3'd1, 64'h3002, 64'h1234_5678_9ABC_ABCD, 64'd0, 0, 0);
      mem_txn(1, 0, 1, 3'd2, 64'h4002, 64'd0, 64'd0, 0, 0);
      alu_op(1'b1, 64'h55, 5'd7);
      mem_txn(1, 0, 1, 3'd0, 64'h10, 64'd0, 64'h0000_0000_0000_0080, 1, 2);
      check("lb_sign", mem_data_out, 64'hFFFF_FFFF_FFFF_FF80);
      mem_txn(1, 1, 1, 3'd3, 64'h7008, 64'hA5A5_0101_F0F0_3C3C, 64'd0, 2, 0);
      mem_txn(1, 0, 1, 3'd3, 64'h8000, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 3);

      // Randomized mix
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 4);
         if (kind == 4) begin
            alu_op(1'($urandom), {$urandom, $urandom}, 5'($urandom));
         end else begin
            f3 = (kind >= 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a = a & ~64'(nbytes(f3) - 1);
            mem_txn(kind < 2, kind >= 2, 1'($urandom), f3, a, {$urandom, $urandom},
                    {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
